// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter and access sequencer for the shared KGP_RISC memory port.
// Optional feature: define ARB_RR_EN for round-robin arbitration (default is fixed priority, port 1 wins).
module mem_port_arbiter #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   input  logic          we0,
   input  logic          we1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          done0,
   output logic          done1,
   output logic [DW-1:0] rdata,
   output logic          sel,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   logic [1:0]    r_state;
   logic [3:0]    r_cnt;
   logic          r_sel;
   logic          r_gnt0;
   logic          r_gnt1;
   logic          r_done0;
   logic          r_done1;
   logic [DW-1:0] r_rdata;
   logic          r_mem_en;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic          r_busy;

   logic          w_any_req;
   logic          w_win;
   logic          w_win_we;
   logic [AW-1:0] w_win_addr;
   logic [DW-1:0] w_win_wdata;

   assign w_any_req = req0 | req1;

`ifdef ARB_RR_EN
   // Pointer holds the last granted port; on conflict the other port wins.
   logic r_rr_ptr;

   assign w_win = (req0 & req1) ? ~r_rr_ptr : req1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr <= 1'b0;
      end else if (r_state == S_IDLE && w_any_req) begin
         r_rr_ptr <= w_win;
      end
   end
`else
   assign w_win = req1;
`endif

   // The 2:1 operand select: the winner's operands are latched straight into the memory-side registers.
   assign w_win_addr  = w_win ? addr1  : addr0;
   assign w_win_wdata = w_win ? wdata1 : wdata0;
   assign w_win_we    = w_win ? we1    : we0;

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_sel       <= 1'b0;
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
         r_done0     <= 1'b0;
         r_done1     <= 1'b0;
         r_rdata     <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_sel       <= w_win;
                  r_gnt0      <= ~w_win;
                  r_gnt1      <= w_win;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= w_win_we;
                  r_mem_addr  <= w_win_addr;
                  r_mem_wdata <= w_win_wdata;
                  r_cnt       <= CNT_INIT;
                  r_busy      <= 1'b1;
                  r_state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (r_cnt == 4'd0) begin
                  if (!r_mem_we) begin
                     r_rdata <= mem_rdata;
                  end
                  r_done0     <= ~r_sel;
                  r_done1     <= r_sel;
                  r_mem_en    <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= '0;
                  r_mem_wdata <= '0;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt0      = r_gnt0;
   assign gnt1      = r_gnt1;
   assign done0     = r_done0;
   assign done1     = r_done1;
   assign rdata     = r_rdata;
   assign sel       = r_sel;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LAT=2 vector table plus conflict, mid-access reset and LAT=1 sequences.
module tb_mem_port_arbiter;

   typedef struct {
      logic        req0, req1;
      logic [31:0] addr0, addr1, wdata0, wdata1;
      logic        we0, we1;
      logic        g0, g1, d0, d1, sel, en, we, busy;
      logic [31:0] maddr, mwdata, rdata;
   } vec_t;

   logic        clk;
   logic        rst_a, rst_b, rst_c;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1;

   logic        gnt0_a, gnt1_a, done0_a, done1_a, sel_a, mem_en_a, mem_we_a, busy_a;
   logic [31:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
   logic        gnt0_b, gnt1_b, done0_b, done1_b, sel_b, mem_en_b, mem_we_b, busy_b;
   logic [31:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
   logic        gnt0_c, gnt1_c, done0_c, done1_c, sel_c, mem_en_c, mem_we_c, busy_c;
   logic [31:0] rdata_c, mem_addr_c, mem_wdata_c, mem_rdata_c;

   int n_checks = 0;
   int n_errors = 0;

   // Memory model: a read returns address + 6.
   assign mem_rdata_a = mem_en_a ? mem_addr_a + 32'h6 : 32'hDEAD_BEEF;
   assign mem_rdata_b = mem_en_b ? mem_addr_b + 32'h6 : 32'hDEAD_BEEF;
   assign mem_rdata_c = mem_en_c ? mem_addr_c + 32'h6 : 32'hDEAD_BEEF;

   mem_port_arbiter #(.AW(32), .DW(32), .LAT(2)) u_lat2 (
      .clk(clk), .rst(rst_a), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
      .gnt0(gnt0_a), .gnt1(gnt1_a), .done0(done0_a), .done1(done1_a), .rdata(rdata_a),
      .sel(sel_a), .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .busy(busy_a));

   mem_port_arbiter #(.AW(32), .DW(32), .LAT(3)) u_lat3 (
      .clk(clk), .rst(rst_b), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
      .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b), .rdata(rdata_b),
      .sel(sel_b), .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b));

   mem_port_arbiter #(.AW(32), .DW(32), .LAT(1)) u_lat1 (
      .clk(clk), .rst(rst_c), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
      .gnt0(gnt0_c), .gnt1(gnt1_c), .done0(done0_c), .done1(done1_c), .rdata(rdata_c),
      .sel(sel_c), .mem_en(mem_en_c), .mem_we(mem_we_c), .mem_addr(mem_addr_c),
      .mem_wdata(mem_wdata_c), .mem_rdata(mem_rdata_c), .busy(busy_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Output bundle: {gnt0, gnt1, done0, done1, sel, mem_en, mem_we, busy, mem_addr, mem_wdata, rdata}
   function automatic logic [103:0] pack(input logic g0, g1, d0, d1, s, en, we, bsy,
                                         input logic [31:0] a, wd, rd);
      return {g0, g1, d0, d1, s, en, we, bsy, a, wd, rd};
   endfunction

   function automatic logic [103:0] out_a();
      return pack(gnt0_a, gnt1_a, done0_a, done1_a, sel_a, mem_en_a, mem_we_a, busy_a,
                  mem_addr_a, mem_wdata_a, rdata_a);
   endfunction

   function automatic logic [103:0] out_b();
      return pack(gnt0_b, gnt1_b, done0_b, done1_b, sel_b, mem_en_b, mem_we_b, busy_b,
                  mem_addr_b, mem_wdata_b, rdata_b);
   endfunction

   function automatic logic [103:0] out_c();
      return pack(gnt0_c, gnt1_c, done0_c, done1_c, sel_c, mem_en_c, mem_we_c, busy_c,
                  mem_addr_c, mem_wdata_c, rdata_c);
   endfunction

   vec_t vecs[16];

   initial begin
      logic [15:0] cg0, cg1, cd0, cd1, cen;
      logic [15:0] exp_g0, exp_g1, exp_d0, exp_d1;
      logic [31:0] addr5, rdata7, rd;
      logic [31:0] exp_addr5, exp_rd7;
      logic        excl, nd;

      // Inputs: req0 req1 addr0 addr1 wdata0 wdata1 we0 we1 | expected after the edge:
      // gnt0 gnt1 done0 done1 sel mem_en mem_we busy mem_addr mem_wdata rdata
      vecs[0]  = '{1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0};
      vecs[2]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h46};
      vecs[3]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h46};
      vecs[4]  = '{1'b0, 1'b1, 32'h0, 32'h10, 32'h0, 32'd5, 1'b0, 1'b1,
                   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'd5, 32'h46};
      vecs[5]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'd5, 32'h46};
      vecs[6]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h46};
      vecs[7]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h46};
      vecs[8]  = '{1'b1, 1'b0, 32'h80, 32'h0, 32'hA5A5, 32'h0, 1'b1, 1'b0,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 32'hA5A5, 32'h46};
      vecs[9]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 32'hA5A5, 32'h46};
      vecs[10] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h46};
      vecs[11] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h46};
      vecs[12] = '{1'b0, 1'b1, 32'h0, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0,
                   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 32'h46};
      // Rows 13-15: a stray port-0 write arrives while busy and must be ignored.
      vecs[13] = '{1'b1, 1'b0, 32'hBAD, 32'h0, 32'hFFFF, 32'h0, 1'b1, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 32'h46};
      vecs[14] = '{1'b1, 1'b0, 32'hBAD, 32'h0, 32'hFFFF, 32'h0, 1'b1, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h106};
      vecs[15] = '{1'b1, 1'b0, 32'hBAD, 32'h0, 32'hFFFF, 32'h0, 1'b1, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h106};

      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_lat2", 128'(out_a()), 128'(0));
      check("reset_lat3", 128'(out_b()), 128'(0));
      check("reset_lat1", 128'(out_c()), 128'(0));

      // LAT=2 vector table, one row per clock
      rst_a = 1'b0;
      for (int i = 0; i < 16; i++) begin
         req0 = vecs[i].req0;     req1 = vecs[i].req1;
         addr0 = vecs[i].addr0;   addr1 = vecs[i].addr1;
         wdata0 = vecs[i].wdata0; wdata1 = vecs[i].wdata1;
         we0 = vecs[i].we0;       we1 = vecs[i].we1;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), 128'(out_a()),
               128'(pack(vecs[i].g0, vecs[i].g1, vecs[i].d0, vecs[i].d1, vecs[i].sel,
                         vecs[i].en, vecs[i].we, vecs[i].busy,
                         vecs[i].maddr, vecs[i].mwdata, vecs[i].rdata)));
      end
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

      // Conflict: both requests held across three transactions on LAT=2
      rst_a = 1'b1;
      @(posedge clk);
      #1;
      rst_a = 1'b0;
      req0 = 1'b1; req1 = 1'b1; addr0 = 32'h20; addr1 = 32'h30;
      cg0 = '0; cg1 = '0; cd0 = '0; cd1 = '0; excl = 1'b0; addr5 = '0; rdata7 = '0;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk);
         #1;
         cg0[4'(e)] = gnt0_a;  cg1[4'(e)] = gnt1_a;
         cd0[4'(e)] = done0_a; cd1[4'(e)] = done1_a;
         if ((gnt0_a && gnt1_a) || (done0_a && done1_a)) excl = 1'b1;
         if (e == 5) addr5 = mem_addr_a;
         if (e == 7) rdata7 = rdata_a;
      end
      req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
`ifdef ARB_RR_EN
      exp_g0 = 16'h0020; exp_g1 = 16'h0202; exp_d0 = 16'h0080; exp_d1 = 16'h0808;
      exp_addr5 = 32'h20; exp_rd7 = 32'h26;
`else
      exp_g0 = 16'h0000; exp_g1 = 16'h0222; exp_d0 = 16'h0000; exp_d1 = 16'h0888;
      exp_addr5 = 32'h30; exp_rd7 = 32'h36;
`endif
      check("conflict_gnt0", 128'(cg0), 128'(exp_g0));
      check("conflict_gnt1", 128'(cg1), 128'(exp_g1));
      check("conflict_done0", 128'(cd0), 128'(exp_d0));
      check("conflict_done1", 128'(cd1), 128'(exp_d1));
      check("conflict_onehot", 128'(excl), 128'(0));
      check("conflict_addr2", 128'(addr5), 128'(exp_addr5));
      check("conflict_rdata2", 128'(rdata7), 128'(exp_rd7));
      rst_a = 1'b1;

      // Reset in the middle of a LAT=3 access, then a clean transaction
      rst_b = 1'b0;
      @(posedge clk);
      #1;
      req0 = 1'b1; addr0 = 32'h44;
      @(posedge clk);
      #1;
      check("midrst_gnt", 128'({gnt0_b, mem_en_b, mem_addr_b}), 128'({1'b1, 1'b1, 32'h44}));
      req0 = 1'b0; addr0 = '0;
      @(posedge clk);
      #1;
      rst_b = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_clear", 128'(out_b()), 128'(0));
      rst_b = 1'b0;
      nd = 1'b0;
      for (int e = 0; e < 6; e++) begin
         @(posedge clk);
         #1;
         if (done0_b || done1_b) nd = 1'b1;
      end
      check("midrst_nodone", 128'(nd), 128'(0));
      req0 = 1'b1; addr0 = 32'h50;
      cg0 = '0; cen = '0; cd0 = '0; rd = '0;
      for (int e = 1; e <= 5; e++) begin
         @(posedge clk);
         #1;
         if (e == 1) begin
            req0 = 1'b0; addr0 = '0;
         end
         cg0[4'(e)] = gnt0_b; cen[4'(e)] = mem_en_b; cd0[4'(e)] = done0_b;
         if (e == 4) rd = rdata_b;
      end
      check("lat3_gnt", 128'(cg0), 128'(16'h0002));
      check("lat3_mem_en", 128'(cen), 128'(16'h000E));
      check("lat3_done", 128'(cd0), 128'(16'h0010));
      check("lat3_rdata", 128'(rd), 128'(32'h56));
      rst_b = 1'b1;

      // LAT=1 with req0 held: grant every 3 cycles
      rst_c = 1'b0;
      @(posedge clk);
      #1;
      req0 = 1'b1; addr0 = 32'h60;
      cg0 = '0; cen = '0; cd0 = '0; rd = '0; excl = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk);
         #1;
         cg0[4'(e)] = gnt0_c; cen[4'(e)] = mem_en_c; cd0[4'(e)] = done0_c;
         if (gnt1_c || done1_c) excl = 1'b1;
         if (e == 2) rd = rdata_c;
      end
      req0 = 1'b0; addr0 = '0;
      check("lat1_gnt", 128'(cg0), 128'(16'h0492));
      check("lat1_mem_en", 128'(cen), 128'(16'h0492));
      check("lat1_done", 128'(cd0), 128'(16'h0924));
      check("lat1_rdata", 128'(rd), 128'(32'h66));
      check("lat1_port1_idle", 128'(excl), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single KGP_RISC memory port. It shares the port between instruction fetch (port 0) and load/store (port 1). It owns the 32-bit 2:1 operand select that steers address, write data and write enable to memory. It runs each granted access for a fixed memory latency and returns read data with a one-cycle completion pulse to the winning requester.

## Interface
- AW, 32, address width
- DW, 32, data width
- LAT, 2, memory access latency in cycles (legal range 1..15)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, level, held until gnt seen
- addr0 / addr1  in  AW  request address
- wdata0 / wdata1  in  DW  store data
- we0 / we1  in  1  1 = write, 0 = read
- gnt0 / gnt1  out  1  one-cycle grant pulse; operands captured
- done0 / done1  out  1  one-cycle completion pulse
- rdata  out  DW  read data, valid while doneX is high
- sel  out  1  current mux select (0 = port 0, 1 = port 1)
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid on the last ACCESS cycle
- busy  out  1  high in ACCESS and DONE

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE**
  - Sample req0 and req1.
  - No request: remain in IDLE.
  - One or more requests: pick a winner per the Configuration section.
  - Register sel = winner. Capture the winner's addr, wdata and we into internal operand registers.
  - Pulse gntX next cycle. Load cnt = LAT-1. Go to ACCESS.
- **ACCESS**
  - mem_en = 1.
  - mem_addr, mem_wdata and mem_we come from the operand registers, through the 2:1 select on sel.
  - Requester inputs are ignored.
  - cnt decrements each cycle.
  - At cnt == 0: if the access is a read, capture mem_rdata into rdata. Go to DONE.
- **DONE**
  - mem_en = 0, mem_we = 0. Pulse done[sel].
  - rdata holds the captured value; it is unchanged on writes.
  - Go to IDLE.
- Requester obligation: deassert req in the cycle after gnt is seen. Requests are sampled only in IDLE, so a req still high on return to IDLE starts a new transaction.
- Only one of gnt0/gnt1 is ever high at a time. The same holds for done0/done1.
- Reset values: gnt0 = gnt1 = done0 = done1 = 0, rdata = 0, sel = 0, mem_en = mem_we = 0, mem_addr = mem_wdata = 0, busy = 0, state = IDLE, cnt = 0, RR pointer = 0.
- Reset mid-transaction: any cycle with rst = 1 aborts the transaction. No done is issued and memory signals drop the next edge.
- LAT = 1: ACCESS lasts exactly one cycle.

## Timing
- Request sampled in IDLE at cycle N.
- gnt in cycle N+1. ACCESS occupies N+1 .. N+LAT; mem_en is high for exactly LAT cycles.
- rdata is captured at the end of N+LAT. done and valid rdata appear in cycle N+LAT+1.
- IDLE at N+LAT+2. The earliest next grant is N+LAT+3.
- Throughput: one access per LAT+2 cycles.
- All outputs are registered. There is no combinational path from req to gnt or to any mem_* output.

## Configuration
- Macro: ARB_RR_EN.
- **Undefined:** fixed priority. Port 1 (load/store) wins whenever req0 and req1 are both high.
- **Defined:** round-robin. A 1-bit pointer records the last granted port.
  - On conflict, the port not last granted wins.
  - A lone requester always wins and updates the pointer.
  - Pointer resets to 0, so the first conflict grants port 1, matching fixed priority.

## Test plan
- **Single read:** LAT = 2, req0 = 1, addr0 = 0x40, we0 = 0, memory returns 0x46 → gnt0 in N+1, mem_addr = 0x40 and mem_en high for N+1..N+2, done0 = 1 with rdata = 0x46 in N+3.
- **Single write:** req1, addr1 = 0x10, wdata1 = 32'd5, we1 = 1 → mem_we = 1 and mem_wdata = 5 for 2 cycles, sel = 1, done1 pulses, rdata unchanged.
- **Conflict, fixed priority:** req0 and req1 together, then both re-asserted → port 1 is granted twice in a row; port 0 waits while req1 persists.
- **Conflict, ARB_RR_EN defined:** req0 and req1 held across three transactions → grant order 1, 0, 1, with done pulses matching.
- **Reset mid-ACCESS:** rst = 1 in N+2 with LAT = 3 → no done, all outputs 0 after the edge; a fresh req0 afterwards completes normally.
- **LAT = 1 back-to-back:** req0 held high → a grant every 3 cycles, mem_en high exactly 1 cycle each time.
